// File: rtl/lpc_host_cmd_queue.sv
// Command FIFO and cycle sequencer driving the lpc_host GPIO-style control inputs;
// a watchdog pulses the host reset and returns a timeout response if a cycle stalls.
module lpc_host_cmd_queue #(
    parameter int DEPTH          = 4,
    parameter int LFRAME_CYCLES  = 2,
    parameter int TIMEOUT        = 64,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_write_i,
    input  logic        cmd_memory_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_write_o,
    output logic        rsp_timeout_o,
    output logic [15:0] ctrl_addr_o,
    output logic [7:0]  ctrl_data_o,
    output logic        ctrl_lframe_o,
    output logic        ctrl_rd_status_o,
    output logic        ctrl_wr_status_o,
    output logic        ctrl_memory_cycle_o,
    output logic        ctrl_nrst_o,
    input  logic [7:0]  ctrl_data_i,
    input  logic        ctrl_ready_i,
    output logic        busy_o,
    output logic [2:0]  state_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  LF_LAST  = 4'(LFRAME_CYCLES - 1);
    localparam logic [3:0]  REC_LAST = 4'(RECOVER_CYCLES - 1);
    localparam logic [7:0]  WD_LAST  = 8'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;
    localparam logic [2:0] ST_RECOVER   = 3'd5;

    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push, pop;
    logic [25:0]   head;

    logic [2:0]  state_q, state_d;
    logic [3:0]  lf_cnt_q, lf_cnt_d;
    logic [3:0]  rec_cnt_q, rec_cnt_d;
    logic [7:0]  wd_q, wd_d;
    logic        wd_hit;

    logic [15:0] ctrl_addr_q, ctrl_addr_d;
    logic [7:0]  ctrl_data_q, ctrl_data_d;
    logic        ctrl_lframe_q, ctrl_lframe_d;
    logic        ctrl_rd_q, ctrl_rd_d;
    logic        ctrl_wr_q, ctrl_wr_d;
    logic        ctrl_mem_q, ctrl_mem_d;
    logic        ctrl_nrst_q, ctrl_nrst_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_write_q, rsp_write_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    assign push   = cmd_valid_i && cmd_ready_q;
    assign head   = mem_q[rd_ptr_q];
    assign wd_hit = (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        lf_cnt_d      = lf_cnt_q;
        rec_cnt_d     = rec_cnt_q;
        wd_d          = wd_q;
        pop           = 1'b0;
        ctrl_addr_d   = ctrl_addr_q;
        ctrl_data_d   = ctrl_data_q;
        ctrl_rd_d     = ctrl_rd_q;
        ctrl_wr_d     = ctrl_wr_q;
        ctrl_mem_d    = ctrl_mem_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_write_d   = rsp_write_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && ctrl_ready_i) begin
                    pop         = 1'b1;
                    ctrl_addr_d = head[25:10];
                    ctrl_data_d = head[9:2];
                    ctrl_wr_d   = head[1];
                    ctrl_rd_d   = !head[1];
                    ctrl_mem_d  = head[0];
                    lf_cnt_d    = '0;
                    wd_d        = '0;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d = wd_q + 8'd1;
                if (wd_hit) begin
                    rec_cnt_d = '0;
                    state_d   = ST_RECOVER;
                end else if (lf_cnt_q == LF_LAST) begin
                    state_d = ST_WAIT_BUSY;
                end else begin
                    lf_cnt_d = lf_cnt_q + 4'd1;
                end
            end
            ST_WAIT_BUSY: begin
                wd_d = wd_q + 8'd1;
                if (!ctrl_ready_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (wd_hit) begin
                    rec_cnt_d = '0;
                    state_d   = ST_RECOVER;
                end
            end
            // A ready edge in the same cycle as the watchdog expiry completes normally.
            ST_WAIT_DONE: begin
                wd_d = wd_q + 8'd1;
                if (ctrl_ready_i) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = ctrl_wr_q ? 8'h00 : ctrl_data_i;
                    rsp_write_d   = ctrl_wr_q;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (wd_hit) begin
                    rec_cnt_d = '0;
                    state_d   = ST_RECOVER;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q == REC_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = 8'hFF;
                    rsp_write_d   = ctrl_wr_q;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    rec_cnt_d = rec_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame and host reset strobes are registered off the current state,
        // which delays each by one clock relative to the state entry.
        ctrl_lframe_d = (state_q != ST_LAUNCH);
        ctrl_nrst_d   = (state_q != ST_RECOVER);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b0;
            state_q       <= ST_IDLE;
            lf_cnt_q      <= '0;
            rec_cnt_q     <= '0;
            wd_q          <= '0;
            ctrl_addr_q   <= '0;
            ctrl_data_q   <= '0;
            ctrl_lframe_q <= 1'b1;
            ctrl_rd_q     <= 1'b0;
            ctrl_wr_q     <= 1'b1;
            ctrl_mem_q    <= 1'b0;
            ctrl_nrst_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            state_q       <= state_d;
            lf_cnt_q      <= lf_cnt_d;
            rec_cnt_q     <= rec_cnt_d;
            wd_q          <= wd_d;
            ctrl_addr_q   <= ctrl_addr_d;
            ctrl_data_q   <= ctrl_data_d;
            ctrl_lframe_q <= ctrl_lframe_d;
            ctrl_rd_q     <= ctrl_rd_d;
            ctrl_wr_q     <= ctrl_wr_d;
            ctrl_mem_q    <= ctrl_mem_d;
            ctrl_nrst_q   <= ctrl_nrst_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_write_q   <= rsp_write_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_addr_i, cmd_data_i, cmd_write_i, cmd_memory_i};
        end
    end

    assign cmd_ready_o         = cmd_ready_q;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_data_o          = rsp_data_q;
    assign rsp_write_o         = rsp_write_q;
    assign rsp_timeout_o       = rsp_timeout_q;
    assign ctrl_addr_o         = ctrl_addr_q;
    assign ctrl_data_o         = ctrl_data_q;
    assign ctrl_lframe_o       = ctrl_lframe_q;
    assign ctrl_rd_status_o    = ctrl_rd_q;
    assign ctrl_wr_status_o    = ctrl_wr_q;
    assign ctrl_memory_cycle_o = ctrl_mem_q;
    assign ctrl_nrst_o         = ctrl_nrst_q;
    assign busy_o              = (state_q != ST_IDLE) || (count_q != '0);
    assign state_o             = state_q;
endmodule

// File: doc/lpc_host_cmd_queue.md
# lpc_host_cmd_queue

Command sequencer that sits directly upstream of `lpc_host` and drives its GPIO-style control inputs. It buffers LPC I/O and memory cycle requests in a small FIFO. It launches each request by framing `ctrl_lframe`, waits on the host's ready handshake, and returns the read data or a write acknowledge on a response channel. A watchdog recovers the host with a reset pulse if a cycle never completes.

## Interface
- `DEPTH`, 4: command FIFO entries; must be a power of two, ≥2.
- `LFRAME_CYCLES`, 2: clocks that `ctrl_lframe_o` is held low per launch; range 1..15.
- `TIMEOUT`, 64: clocks allowed from launch until the host returns ready; range 8..255.
- `RECOVER_CYCLES`, 4: clocks that `ctrl_nrst_o` is held low after a timeout; range 1..15.

Ports:
- `clk_i` in 1: single clock, same clock as `lpc_host.clk_i`.
- `rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: FIFO can accept a command.
- `cmd_addr_i` in 16: LPC address.
- `cmd_data_i` in 8: write data; ignored for reads.
- `cmd_write_i` in 1: 1 = write, 0 = read.
- `cmd_memory_i` in 1: 1 = memory cycle, 0 = I/O cycle.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_data_o` out 8: read data; 0x00 for writes; 0xFF on timeout.
- `rsp_write_o` out 1: echo of the command's write flag.
- `rsp_timeout_o` out 1: cycle was aborted by the watchdog.
- `ctrl_addr_o` out 16, `ctrl_data_o` out 8: to host `ctrl_addr_i` / `ctrl_data_i`.
- `ctrl_lframe_o` out 1: to host `ctrl_lframe_i`; active low.
- `ctrl_rd_status_o` out 1, `ctrl_wr_status_o` out 1: to host rd/wr status.
- `ctrl_memory_cycle_o` out 1: to host memory-cycle select.
- `ctrl_nrst_o` out 1: to host `ctrl_nrst_i`; active low.
- `ctrl_data_i` in 8, `ctrl_ready_i` in 1: from host `ctrl_data_o` / `ctrl_ready_o`.
- `busy_o` out 1: FSM not in IDLE, or FIFO not empty.
- `state_o` out 3: current FSM state encoding.

## Operation
- **FIFO:** `DEPTH` entries × 26 bits (addr, data, write, memory).
  - Push when `cmd_valid_i && cmd_ready_o`.
  - `cmd_ready_o = (count != DEPTH)`, registered from count; there is no bypass path.
  - Pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits.
  - Push and pop in the same cycle leaves count unchanged.
- **FSM states** (`state_o` encoding):
  - **IDLE (0):** when the FIFO is non-empty and `ctrl_ready_i`=1, pop the head into the ctrl registers and go to LAUNCH.
  - **LAUNCH (1):** `ctrl_lframe_o`=0 for `LFRAME_CYCLES` clocks, then go to WAIT_BUSY.
  - **WAIT_BUSY (2):** wait for `ctrl_ready_i`=0, then go to WAIT_DONE.
  - **WAIT_DONE (3):** wait for `ctrl_ready_i`=1. Capture `ctrl_data_i` (reads) into `rsp_data_o`, then go to RESP.
  - **RESP (4):** `rsp_valid_o`=1 until `rsp_ready_i`=1, then go to IDLE. No new launch happens while a response is pending.
  - **RECOVER (5):** `ctrl_nrst_o`=0 for `RECOVER_CYCLES` clocks, then go to RESP with `rsp_timeout_o`=1 and `rsp_data_o`=0xFF.
- **Watchdog:** an 8-bit counter clears on entry to LAUNCH and increments in LAUNCH, WAIT_BUSY and WAIT_DONE.
  - When the count reaches `TIMEOUT`, go to RECOVER from any of those states.
  - If the timeout and the ready edge occur in the same cycle, the ready edge wins.
- **Status lines:** `ctrl_rd_status_o` = !write and `ctrl_wr_status_o` = write. Both are held from pop until the FSM returns to IDLE.
- **Response fields:** `rsp_*` are stable while `rsp_valid_o`=1.
- **Reset:** `rst_i` mid-operation aborts any cycle, empties the FIFO, and discards any pending response. No response is issued for the aborted command.

## Timing
- **Reset values:**
  - `cmd_ready_o`=0 during reset, 1 on the first clock after reset.
  - `rsp_valid_o`=0, `rsp_data_o`=0x00, `rsp_write_o`=0, `rsp_timeout_o`=0.
  - `ctrl_addr_o`=0, `ctrl_data_o`=0.
  - `ctrl_lframe_o`=1, `ctrl_rd_status_o`=0, `ctrl_wr_status_o`=1, `ctrl_memory_cycle_o`=0.
  - `ctrl_nrst_o`=0 while `rst_i`=1, 1 afterwards.
  - `busy_o`=0, `state_o`=0.
- **Launch latency:** with the FIFO empty, a command accepted at edge N is popped at edge N+1. `ctrl_lframe_o` falls at edge N+2 and rises at edge N+2+`LFRAME_CYCLES`.
- **Control lines:** ctrl address, data and flags are valid from edge N+1 and remain stable through the end of the cycle.
- **Response latency:** `rsp_valid_o` rises one clock after `ctrl_ready_i` is sampled high in WAIT_DONE.
  - Back-to-back throughput: the next pop occurs in IDLE on the clock after `rsp_ready_i` is accepted.
- **Registered outputs:** all outputs are registered except `busy_o`.

## Test plan
- **Single write:** reset, then push addr 0xF0F0, data 0x5A, write, I/O. Required: `ctrl_lframe_o` low 2 clocks starting 2 clocks after acceptance, `ctrl_wr_status_o`=1. Model host drops ready for 10 clocks. Response has write=1, data 0x00, timeout=0.
- **Read:** push read of 0x0080, memory. Host returns 0xA5. Required: `ctrl_memory_cycle_o`=1 and `rsp_data_o`=0xA5.
- **FIFO full:** hold `rsp_ready_i`=0 and push 6 commands. Required: `cmd_ready_o` falls after 1 in flight + 4 queued. Responses then drain in order with addresses 0..5.
- **Timeout:** host never raises ready. Required: RECOVER entered 64 clocks after launch and `ctrl_nrst_o` low 4 clocks. Response has timeout=1, data 0xFF, and the next command proceeds normally.
- **Reset mid-cycle:** assert `rst_i` during WAIT_DONE with 2 commands queued. Required: all outputs at reset values next clock and no response is issued.
- **Wrap-around:** issue 129 write/read pairs with addr i, data i. Reads return 0xBB+i (mod 256). There are no lost or duplicated commands across pointer wrap.
